// File: rtl/instruction_encoder.sv
// ============================================================================
// Module   : instruction_encoder
// Function : Encodes R/I/U/B field sets into 32-bit words. Results pass through a
//            2-entry registered output FIFO that carries an error flag per word.
// Option   : ENCODER_ERRCNT_EN adds a saturating 8-bit error counter (err_count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [3:0]  aluop,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] komut,
  output logic        hata
`ifdef ENCODER_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam logic [6:0] OP_R = 7'b0000001;
  localparam logic [6:0] OP_I = 7'b0000011;
  localparam logic [6:0] OP_U = 7'b0000111;
  localparam logic [6:0] OP_B = 7'b0001111;

  logic [31:0] enc_word;
  logic        enc_err;

  always_comb begin
    enc_word = {25'b0, opcode};
    enc_err  = 1'b1;
    case (opcode)
      OP_R: begin
        enc_word = {1'b0, aluop[3], 5'b0, rs2, rs1, aluop[2:0], rd, opcode};
        enc_err  = 1'b0;
      end
      OP_I: begin
        enc_word = {imm[11:0], rs1, aluop[2:0], rd, opcode};
        enc_err  = (|imm[31:12]) | aluop[3];
      end
      OP_U: begin
        enc_word = {imm[19:0], rd, opcode};
        enc_err  = |imm[31:20];
      end
      OP_B: begin
        enc_word = {imm[12:6], rs2, rs1, aluop[2:0], imm[5:1], opcode};
        enc_err  = (|imm[31:13]) | imm[0] | aluop[3];
      end
      default: begin
        enc_word = {25'b0, opcode};
        enc_err  = 1'b1;
      end
    endcase
  end

  // Shift-style FIFO: the head entry drives the outputs directly from flops.
  logic [1:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic [31:0] head_word_q, head_word_d, tail_word_q, tail_word_d;
  logic        head_err_q, head_err_d, tail_err_q, tail_err_d;
  logic        push, pop;

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready = rst_n & (count_q != 2'd2);
  assign push     = in_valid & in_ready;
  assign pop      = valid_q & out_ready;

  always_comb begin
    count_d     = count_q;
    head_word_d = head_word_q;
    head_err_d  = head_err_q;
    tail_word_d = tail_word_q;
    tail_err_d  = tail_err_q;
    case ({push, pop})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          head_word_d = enc_word;
          head_err_d  = enc_err;
        end else begin
          tail_word_d = enc_word;
          tail_err_d  = enc_err;
        end
      end
      2'b01: begin
        count_d     = count_q - 2'd1;
        head_word_d = tail_word_q;
        head_err_d  = tail_err_q;
      end
      2'b11: begin
        // Push needs count<2 and pop needs count>0, so count is 1 here.
        head_word_d = enc_word;
        head_err_d  = enc_err;
      end
      default: ;
    endcase
    valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      valid_q     <= 1'b0;
      head_word_q <= 32'h0;
      head_err_q  <= 1'b0;
      tail_word_q <= 32'h0;
      tail_err_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      valid_q     <= valid_d;
      head_word_q <= head_word_d;
      head_err_q  <= head_err_d;
      tail_word_q <= tail_word_d;
      tail_err_q  <= tail_err_d;
    end
  end

  assign out_valid = valid_q;
  assign komut     = head_word_q;
  assign hata      = head_err_q;

`ifdef ENCODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && enc_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_encoder.sv
// ============================================================================
// Module   : tb_instruction_encoder
// Function : Directed vector table plus backpressure/reset sequences for
//            instruction_encoder; ENCODER_ERRCNT_EN enables counter checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [3:0]  aluop;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] komut;
  logic        hata;
`ifdef ENCODER_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  instruction_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .aluop     (aluop),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .komut     (komut),
    .hata      (hata)
`ifdef ENCODER_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [3:0]  alu;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  d;
    logic [31:0] im;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];
  int   n_pass  = 0;
  int   n_total = 0;
  logic [7:0] exp_errcnt = 8'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    opcode = v.op;
    aluop  = v.alu;
    rs1    = v.r1;
    rs2    = v.r2;
    rd     = v.d;
    imm    = v.im;
  endtask

  task automatic check_errcnt(input string nm);
`ifdef ENCODER_ERRCNT_EN
    chk(nm, {24'h0, err_count}, {24'h0, exp_errcnt});
`else
    if (nm.len() == 0) $display("empty check name");
`endif
  endtask

  task automatic send_vec(input vec_t v);
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1 chk({v.name, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({v.name, "_out_valid"}, out_valid, 1);
    chk({v.name, "_komut"}, komut, v.exp_word);
    chk({v.name, "_hata"}, hata, v.exp_err);
    if (v.exp_err && exp_errcnt != 8'hFF) exp_errcnt = exp_errcnt + 8'd1;
    check_errcnt({v.name, "_err_count"});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({v.name, "_drained"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"r_basic",   7'h01, 4'b1000, 5'd2,  5'd3, 5'd1,  32'h0,        32'h4031_0081, 1'b0};
    vecs[1]  = '{"r_imm_ign", 7'h01, 4'b1000, 5'd2,  5'd3, 5'd1,  32'hFFFF_FFFF, 32'h4031_0081, 1'b0};
    vecs[2]  = '{"i_basic",   7'h03, 4'b0010, 5'd5,  5'd0, 5'd6,  32'h0000_07FF, 32'h7FF2_A303, 1'b0};
    vecs[3]  = '{"i_big_imm", 7'h03, 4'b0010, 5'd5,  5'd0, 5'd6,  32'h0000_1000, 32'h0002_A303, 1'b1};
    vecs[4]  = '{"i_alu3",    7'h03, 4'b1010, 5'd5,  5'd0, 5'd6,  32'h0000_07FF, 32'h7FF2_A303, 1'b1};
    vecs[5]  = '{"u_basic",   7'h07, 4'b1111, 5'd31, 5'd0, 5'd10, 32'h0001_2345, 32'h1234_5507, 1'b0};
    vecs[6]  = '{"u_big_imm", 7'h07, 4'b0000, 5'd0,  5'd0, 5'd10, 32'h0011_2345, 32'h1234_5507, 1'b1};
    vecs[7]  = '{"b_basic",   7'h0F, 4'b0001, 5'd3,  5'd4, 5'd0,  32'h0000_0ABC, 32'h5441_9F0F, 1'b0};
    vecs[8]  = '{"b_odd_imm", 7'h0F, 4'b0001, 5'd3,  5'd4, 5'd0,  32'h0000_0ABD, 32'h5441_9F0F, 1'b1};
    vecs[9]  = '{"b_imm12",   7'h0F, 4'b0001, 5'd3,  5'd4, 5'd0,  32'h0000_1ABC, 32'hD441_9F0F, 1'b0};
    vecs[10] = '{"bad_op55",  7'h55, 4'b0000, 5'd0,  5'd0, 5'd0,  32'h0,        32'h0000_0055, 1'b1};
    vecs[11] = '{"bad_op00",  7'h00, 4'b0111, 5'd9,  5'd7, 5'd5,  32'h0000_0FFF, 32'h0000_0000, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(vecs[0]);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_komut", komut, 32'h0);
    chk("rst_hata", hata, 0);
    chk("rst_in_ready", in_ready, 0);
    check_errcnt("rst_err_count");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) send_vec(vecs[i]);

    // Backpressure: A and B fill the FIFO, C waits until space frees up.
    @(negedge clk);
    out_ready = 1'b0;
    drive(vecs[0]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_a_valid", out_valid, 1);
    chk("bp_a_ready", in_ready, 1);
    @(negedge clk);
    drive(vecs[2]);
    @(posedge clk); #1;
    chk("bp_full_ready", in_ready, 0);
    chk("bp_head_a", komut, vecs[0].exp_word);
    @(negedge clk);
    drive(vecs[5]);
    @(posedge clk); #1;
    chk("bp_stall_ready", in_ready, 0);
    chk("bp_stall_head", komut, vecs[0].exp_word);
    @(posedge clk); #1;
    chk("bp_stall_head2", komut, vecs[0].exp_word);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_head_b", komut, vecs[2].exp_word);
    chk("bp_ready_after_pop", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_head_c", komut, vecs[5].exp_word);
    chk("bp_c_valid", out_valid, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_empty", out_valid, 0);
    out_ready = 1'b0;

`ifdef ENCODER_ERRCNT_EN
    @(negedge clk);
    drive(vecs[10]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (260) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_errcnt = 8'hFF;
    check_errcnt("sat_err_count");
    chk("sat_drained", out_valid, 0);
`endif

    // Reset with a full FIFO.
    @(negedge clk);
    drive(vecs[0]);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(vecs[7]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    exp_errcnt = 8'h0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_komut", komut, 32'h0);
    chk("mid_rst_hata", hata, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    check_errcnt("mid_rst_err_count");
    @(posedge clk); #1;
    chk("mid_rst_hold_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("post_rst_no_stale", out_valid, 0);
    chk("post_rst_komut", komut, 32'h0);
    send_vec(vecs[10]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
